// File: rtl/scan_chain_target.sv
// scan_chain_target: chip-side responder for the host scan-chain link.
// Oversamples sc_clk/sc_data on clki, deserialises an LSB-first config word,
// returns a latched status word MSB-first on sc_out, and closes each frame
// after TIMEOUT quiet cycles with a good/short/over verdict.
// Optional build macro: SCT_PARITY_EN adds an even-parity rise after the
// payload and the err_parity output.
module scan_chain_target #(
  parameter int DATA_LEN   = 64,
  parameter int LEAD_BITS  = 1,
  parameter int TRAIL_BITS = 1,
  parameter int TIMEOUT    = 3000000
) (
  input  logic                clki,
  input  logic                rst,
  input  logic                sc_clk,
  input  logic                sc_data,
  input  logic [DATA_LEN-1:0] status_word,
  output logic                sc_out,
  output logic [DATA_LEN-1:0] cfg_word,
  output logic                cfg_valid,
  output logic                busy,
  output logic                err_short,
  output logic                err_over,
`ifdef SCT_PARITY_EN
  output logic                err_parity,
`endif
  output logic [7:0]          err_cnt
);

`ifdef SCT_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int N  = LEAD_BITS + DATA_LEN + PAR_BITS + TRAIL_BITS;
  localparam int CW = $clog2(N + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(DATA_LEN);

  localparam logic [CW-1:0] C_N     = CW'(N);
  localparam logic [CW-1:0] C_MAX   = CW'(N + 1);
  localparam logic [CW-1:0] C_FIRST = CW'(LEAD_BITS + 1);
  localparam logic [CW-1:0] C_LAST  = CW'(LEAD_BITS + DATA_LEN);
  localparam logic [CW-1:0] C_DLEN  = CW'(DATA_LEN);
`ifdef SCT_PARITY_EN
  localparam logic [CW-1:0] C_PAR   = CW'(LEAD_BITS + DATA_LEN + 1);
`endif
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CLOSE = 2'd2;

  logic                r_clk_s1, r_clk_s2, r_clk_d;
  logic                r_dat_s1, r_dat_s2;
  logic [1:0]          r_state;
  logic [CW-1:0]       r_rise_cnt;
  logic [TW-1:0]       r_to_cnt;
  logic [DATA_LEN-1:0] r_rx_sr;
  logic [DATA_LEN-1:0] r_status;
  logic [DATA_LEN-1:0] r_cfg;
  logic                r_sc_out;
  logic                r_cfg_valid;
  logic                r_busy;
  logic                r_err_short;
  logic                r_err_over;
  logic [7:0]          r_err_cnt;
`ifdef SCT_PARITY_EN
  logic                r_par;
  logic                r_err_parity;
`endif

  logic                w_rise;
  logic                w_take;
  logic                w_in_pay;
  logic [CW-1:0]       w_cnt_nx;
  logic [DATA_LEN-1:0] w_tx_word;
  logic [IW-1:0]       w_tx_idx;
  logic                w_tx_bit;

  // Two-flop synchronisers; the clock chain resets to the idle-high level so
  // leaving reset with sc_clk high is not mistaken for a rise.
  always_ff @(posedge clki) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b0;
      r_dat_s2 <= 1'b0;
    end else begin
      r_clk_s1 <= sc_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= sc_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_rise = r_clk_s2 & ~r_clk_d;
  // Rises arriving during the single CLOSE cycle are not part of any frame.
  assign w_take = w_rise && (r_state != S_CLOSE);

  // Rise number this rise will carry, and the status bit it returns.
  always_comb begin
    w_cnt_nx = r_rise_cnt + CW'(1);
    if (r_state == S_IDLE)         w_cnt_nx = CW'(1);
    else if (r_rise_cnt == C_MAX)  w_cnt_nx = C_MAX;
    w_in_pay  = (w_cnt_nx >= C_FIRST) && (w_cnt_nx <= C_LAST);
    // First rise of a frame uses the live word, later rises the latched copy.
    w_tx_word = (r_state == S_IDLE) ? status_word : r_status;
    w_tx_idx  = IW'(DATA_LEN - int'(w_cnt_nx));
    w_tx_bit  = (w_cnt_nx <= C_DLEN) ? w_tx_word[w_tx_idx] : 1'b0;
  end

  // Frame FSM, rise/timeout counters, shift registers and verdict pulses.
  always_ff @(posedge clki) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rise_cnt  <= '0;
      r_to_cnt    <= '0;
      r_rx_sr     <= '0;
      r_status    <= '0;
      r_cfg       <= '0;
      r_sc_out    <= 1'b0;
      r_cfg_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_over  <= 1'b0;
      r_err_cnt   <= '0;
`ifdef SCT_PARITY_EN
      r_par        <= 1'b0;
      r_err_parity <= 1'b0;
`endif
    end else begin
      r_cfg_valid <= 1'b0;
      r_err_short <= 1'b0;
      r_err_over  <= 1'b0;
`ifdef SCT_PARITY_EN
      r_err_parity <= 1'b0;
`endif

      if (w_rise)                r_to_cnt <= '0;
      else if (r_to_cnt != T_MAX) r_to_cnt <= r_to_cnt + TW'(1);

      if (w_take) begin
        r_rise_cnt <= w_cnt_nx;
        r_sc_out   <= w_tx_bit;
        if (w_in_pay) r_rx_sr <= {r_dat_s2, r_rx_sr[DATA_LEN-1:1]};
`ifdef SCT_PARITY_EN
        if (w_cnt_nx == C_PAR) r_par <= r_dat_s2;
`endif
      end

      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state  <= S_SHIFT;
            r_busy   <= 1'b1;
            r_status <= status_word;
          end
        end
        S_SHIFT: begin
          // A rise in the timeout cycle keeps the frame open.
          if (!w_rise && (r_to_cnt == T_MAX)) r_state <= S_CLOSE;
        end
        S_CLOSE: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_sc_out <= 1'b0;
          if (r_rise_cnt < C_N) begin
            r_err_short <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end else if (r_rise_cnt > C_N) begin
            r_err_over <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
`ifdef SCT_PARITY_EN
          end else if (r_par != ^r_rx_sr) begin
            r_err_parity <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
`endif
          end else begin
            r_cfg       <= r_rx_sr;
            r_cfg_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sc_out    = r_sc_out;
  assign cfg_word  = r_cfg;
  assign cfg_valid = r_cfg_valid;
  assign busy      = r_busy;
  assign err_short = r_err_short;
  assign err_over  = r_err_over;
  assign err_cnt   = r_err_cnt;
`ifdef SCT_PARITY_EN
  assign err_parity = r_err_parity;
`endif

endmodule

// File: tb/tb_scan_chain_target.sv
// Bench for scan_chain_target: a host-side frame driver plus a scoreboard.
// The driver pushes the expected frame verdict; a monitor pops it whenever
// the DUT pulses cfg_valid or an error.
module tb_scan_chain_target;
  localparam int DL = 64;
  localparam int LB = 1;
  localparam int TB = 1;
  localparam int TO = 40;
`ifdef SCT_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NR = LB + DL + PB + TB;

  logic          clki = 1'b0;
  logic          rst, sc_clk, sc_data;
  logic [DL-1:0] status_word;
  logic          sc_out, cfg_valid, busy, err_short, err_over;
  logic [DL-1:0] cfg_word;
  logic [7:0]    err_cnt;
`ifdef SCT_PARITY_EN
  logic          err_parity;
`endif

  scan_chain_target #(.DATA_LEN(DL), .LEAD_BITS(LB), .TRAIL_BITS(TB), .TIMEOUT(TO)) dut (
    .clki(clki), .rst(rst), .sc_clk(sc_clk), .sc_data(sc_data),
    .status_word(status_word), .sc_out(sc_out), .cfg_word(cfg_word),
    .cfg_valid(cfg_valid), .busy(busy), .err_short(err_short), .err_over(err_over),
`ifdef SCT_PARITY_EN
    .err_parity(err_parity),
`endif
    .err_cnt(err_cnt));

  always #5 clki = ~clki;

  int cyc = 0;
  always @(posedge clki) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 good, 1 short, 2 over, 3 parity
    logic [63:0] word;
    logic [7:0]  ecnt;
  } exp_t;
  exp_t expq[$];

  int          vectors = 0;
  int          errors  = 0;
  logic [63:0] m_cfg   = '0;
  int          m_ecnt  = 0;
  int          last_rise_c0 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every verdict pulse consumes one scoreboard entry.
  always @(negedge clki) begin : mon
    int   n, k;
    exp_t e;
    if (rst === 1'b0) begin
      n = int'(cfg_valid) + int'(err_short) + int'(err_over);
`ifdef SCT_PARITY_EN
      n = n + int'(err_parity);
`endif
      k = cfg_valid ? 0 : err_short ? 1 : err_over ? 2 : 3;
      if (n > 1) check("single_pulse", 64'(n), 64'd1);
      else if (n == 1) begin
        if (expq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_pulse: kind=%0d with no frame pending", k);
        end else begin
          e = expq.pop_front();
          check("verdict_kind", 64'(k), 64'(e.kind));
          check("cfg_word", cfg_word, e.word);
          check("err_cnt", 64'(err_cnt), 64'(e.ecnt));
          check("close_latency", 64'(cyc - last_rise_c0), 64'(TO + 4));
          check("busy_at_close", 64'(busy), 64'd0);
        end
      end
    end
  end

  // Host side: one frame of nr rises; returns status captured from sc_out.
  task automatic frame(input int nr, input logic [63:0] pay, input logic [63:0] stat,
                       input bit pbad);
    int          ph;
    logic [63:0] cap;
    bit          tail_ok;
    bit          b;
    ph      = $urandom_range(3, 5);
    cap     = '0;
    tail_ok = 1'b1;
    status_word = stat;
    @(negedge clki);
    for (int r = 1; r <= nr; r++) begin
      if (r >= LB + 1 && r <= LB + DL) b = pay[r-LB-1];
      else if (PB == 1 && r == LB + DL + 1) b = (^pay) ^ pbad;
      else b = 1'($urandom);
      sc_clk  = 1'b0;
      sc_data = b;
      repeat (ph) @(negedge clki);
      sc_clk = 1'b1;
      last_rise_c0 = cyc + 1;
      repeat (ph) @(negedge clki);
      if (r <= DL) cap[DL-r] = sc_out;
      else if (sc_out !== 1'b0) tail_ok = 1'b0;
      // Status may change once the frame has latched it.
      if (r == 1) status_word = {$urandom, $urandom};
    end
    if (nr > 0) begin
      check("busy_in_frame", 64'(busy), 64'd1);
      if (nr == NR && !pbad) begin
        m_cfg = pay;
        expq.push_back('{0, m_cfg, 8'(m_ecnt)});
      end else begin
        m_ecnt = (m_ecnt < 255) ? m_ecnt + 1 : 255;
        expq.push_back('{(nr < NR) ? 1 : (nr > NR) ? 2 : 3, m_cfg, 8'(m_ecnt)});
      end
    end
    if (nr >= DL) check("status_capture", cap, stat);
    if (nr > DL)  check("sc_out_tail_zero", 64'(tail_ok), 64'd1);
    repeat (TO + 15) @(negedge clki);
    if (expq.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL missing_verdict: %0d pending after frame of %0d rises", expq.size(), nr);
      expq.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nr;
    rst = 1'b1; sc_clk = 1'b1; sc_data = 1'b0; status_word = '0;
    repeat (3) @(negedge clki);
    check("reset_cfg_word", cfg_word, 64'd0);
    check("reset_ctrl", 64'({sc_out, cfg_valid, busy, err_short, err_over, err_cnt}), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clki);

    // Directed frames: good, short, over.
    frame(NR, 64'hA5A5_0000_FFFF_1234, 64'hDEAD_BEEF_0123_4567, 1'b0);
    frame(40, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    frame(NR + 2, {$urandom, $urandom}, 64'hFEED_0000_1111_2222, 1'b0);

    // Reset in the middle of a frame discards it silently.
    @(negedge clki);
    for (int r = 0; r < 20; r++) begin
      sc_clk = 1'b0; sc_data = 1'($urandom);
      repeat (4) @(negedge clki);
      sc_clk = 1'b1;
      repeat (4) @(negedge clki);
    end
    check("busy_before_reset", 64'(busy), 64'd1);
    rst = 1'b1;
    repeat (3) @(negedge clki);
    check("midreset_cfg_word", cfg_word, 64'd0);
    check("midreset_ctrl", 64'({sc_out, cfg_valid, busy, err_short, err_over, err_cnt}), 64'd0);
    rst = 1'b0;
    m_cfg = '0;
    m_ecnt = 0;
    repeat (TO + 15) @(negedge clki);
    check("post_reset_idle", 64'({busy, err_cnt}), 64'd0);

    // Randomized frames, mostly well-formed.
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 4))
        0, 1, 2: nr = NR;
        3:       nr = ($urandom_range(0, 1) != 0) ? NR + 1 : NR - 1;
        default: nr = $urandom_range(1, NR + 3);
      endcase
      frame(nr, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    end

    // Drive err_cnt into saturation with short frames, then one good frame.
    while (m_ecnt < 255) frame($urandom_range(1, 3), '0, '0, 1'b0);
    frame(2, '0, '0, 1'b0);
    check("err_cnt_saturated", 64'(err_cnt), 64'd255);
    frame(NR, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);

`ifdef SCT_PARITY_EN
    frame(NR, 64'h1, {$urandom, $urandom}, 1'b1);
    frame(NR, 64'h1, {$urandom, $urandom}, 1'b0);
    check("parity_good_word", cfg_word, 64'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
